// File: rtl/alu_writeback_pkg.sv
// alu_writeback_pkg: ALUControl opcodes, exception causes and FSM states shared by the ALU result path
package alu_writeback_pkg;
  localparam logic [2:0] ALU_ADD     = 3'b000;
  localparam logic [2:0] ALU_SUB     = 3'b001;
  localparam logic [2:0] ALU_SWAP    = 3'b011;
  localparam logic [2:0] ALU_ILL_MIN = 3'b110;
  localparam logic [1:0] EXC_OVF     = 2'b01;
  localparam logic [1:0] EXC_ILL     = 2'b10;
  typedef enum logic {IDLE, WR_B} state_t;
endpackage

// File: rtl/alu_writeback.sv
// alu_writeback: ALU result -> register-file write port (clk/reset, in_valid/in_ready, alu_ctrl/result/overflow, rd_a/rd_b, pc in; rf_we/waddr/wdata, exc_valid/cause/pc out), SWAP takes two write cycles
module alu_writeback
  import alu_writeback_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 4,
  parameter int R0_HARDWIRED = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          alu_ctrl,
  input  logic [2*DATA_W-1:0] alu_result,
  input  logic                alu_overflow,
  input  logic [ADDR_W-1:0]   rd_a,
  input  logic [ADDR_W-1:0]   rd_b,
  input  logic [15:0]         pc,
  output logic                rf_we,
  output logic [ADDR_W-1:0]   rf_waddr,
  output logic [DATA_W-1:0]   rf_wdata,
  output logic                exc_valid,
  output logic [1:0]          exc_cause,
  output logic [15:0]         exc_pc
);
  state_t state;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;
  logic ok_a, ok_b, illegal, ovf_exc, swap;
  assign in_ready = state == IDLE;
  assign ok_a     = !(R0_HARDWIRED != 0 && rd_a == '0);
  assign ok_b     = !(R0_HARDWIRED != 0 && b_addr == '0);
  assign illegal  = alu_ctrl >= ALU_ILL_MIN;
  assign ovf_exc  = alu_overflow && (alu_ctrl == ALU_ADD || alu_ctrl == ALU_SUB);
  assign swap     = alu_ctrl == ALU_SWAP;
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      exc_valid <= 1'b0;
      exc_cause <= '0;
      exc_pc    <= '0;
      b_addr    <= '0;
      b_data    <= '0;
    end else begin
      rf_we     <= 1'b0;
      exc_valid <= 1'b0;
      if (state == WR_B) begin
        rf_we    <= ok_b;
        rf_waddr <= b_addr;
        rf_wdata <= b_data;
        state    <= IDLE;
      end else if (in_valid) begin
        if (illegal || ovf_exc) begin
          exc_valid <= 1'b1;
          exc_cause <= illegal ? EXC_ILL : EXC_OVF;
          exc_pc    <= pc;
        end else begin
          rf_we    <= ok_a;
          rf_waddr <= rd_a;
          rf_wdata <= swap ? alu_result[2*DATA_W-1:DATA_W] : alu_result[DATA_W-1:0];
        end
        if (swap) begin
          state  <= WR_B;
          b_addr <= rd_b;
          b_data <= alu_result[DATA_W-1:0];
        end
      end
    end
  end
endmodule
